// File: rtl/bbox_cand_sorter.sv
// Serializes the hit children of one bbox response as beats sorted near-to-far by entry t.
// The first beat is valid 2 edges after input acceptance, and the input is blocked until the last beat handshakes. Output beats hold steady under stall.
module bbox_cand_sorter #(
  parameter int RID_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [RID_WIDTH+194:0] bbox_resp_stream_rsc_dat,
  input  logic                   bbox_resp_stream_rsc_vld,
  output logic                   bbox_resp_stream_rsc_rdy,
  output logic [RID_WIDTH+36:0]  cand_stream_rsc_dat,
  output logic                   cand_stream_rsc_vld,
  input  logic                   cand_stream_rsc_rdy
);

  typedef enum logic [1:0] {IDLE, SORT, EMIT} state_t;

  typedef struct packed {
    logic                 last;
    logic [1:0]           cnt;
    logic [1:0]           idx;
    logic [31:0]          tmin;
    logic [RID_WIDTH-1:0] rid;
  } cand_t;

  state_t               state;
  logic [RID_WIDTH-1:0] rid_q;
  logic [2:0][31:0]     t_q;
  logic [2:0]           hit_q;
  logic [2:0][1:0]      ord_q;
  logic [1:0]           cnt_q;
  logic [1:0]           ptr_q;

  logic [2:0][31:0]     key;
  logic [2:0][1:0]      rank;
  logic [2:0][1:0]      sort_ord;
  logic [1:0]           sort_cnt;
  logic [1:0]           cur_idx;
  logic [31:0]          cur_t;
  cand_t                beat;

  // Exit times are carried by the response format but play no part in ordering.
  logic unused_exit;
  assign unused_exit = ^{bbox_resp_stream_rsc_dat[RID_WIDTH+63:RID_WIDTH+32],
                         bbox_resp_stream_rsc_dat[RID_WIDTH+127:RID_WIDTH+96],
                         bbox_resp_stream_rsc_dat[RID_WIDTH+191:RID_WIDTH+160]};

  // Map float32 to an unsigned key with the same total order (-0 sorts below +0).
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      key[i] = t_q[i][31] ? ~t_q[i] : (t_q[i] ^ 32'h8000_0000);
    end
  end

  // Each hit candidate's slot is the number of hit candidates that must precede it.
  always_comb begin
    sort_ord = '1;
    rank     = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (j != i && hit_q[j] &&
            (key[j] < key[i] || (key[j] == key[i] && j < i))) begin
          rank[i] = rank[i] + 2'd1;
        end
      end
      if (hit_q[i]) begin
        sort_ord[rank[i]] = 2'(i);
      end
    end
    sort_cnt = {1'b0, hit_q[0]} + {1'b0, hit_q[1]} + {1'b0, hit_q[2]};
  end

  always_comb begin
    case (ptr_q)
      2'd0:    cur_idx = ord_q[0];
      2'd1:    cur_idx = ord_q[1];
      default: cur_idx = ord_q[2];
    endcase
    case (cur_idx)
      2'd0:    cur_t = t_q[0];
      2'd1:    cur_t = t_q[1];
      default: cur_t = t_q[2];
    endcase
    beat = '0;
    if (state == EMIT) begin
      beat.rid = rid_q;
      beat.cnt = cnt_q;
      if (cnt_q == 2'd0) begin
        beat.idx  = 2'd3;
        beat.last = 1'b1;
      end else begin
        beat.idx  = cur_idx;
        beat.tmin = cur_t;
        beat.last = (ptr_q == cnt_q - 2'd1);
      end
    end
  end

  assign cand_stream_rsc_dat      = beat;
  assign cand_stream_rsc_vld      = (state == EMIT);
  assign bbox_resp_stream_rsc_rdy = (state == IDLE);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      rid_q <= '0;
      t_q   <= '0;
      hit_q <= '0;
      ord_q <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bbox_resp_stream_rsc_vld) begin
            rid_q <= bbox_resp_stream_rsc_dat[RID_WIDTH-1:0];
            t_q[0] <= bbox_resp_stream_rsc_dat[RID_WIDTH+31:RID_WIDTH];
            t_q[1] <= bbox_resp_stream_rsc_dat[RID_WIDTH+95:RID_WIDTH+64];
            t_q[2] <= bbox_resp_stream_rsc_dat[RID_WIDTH+159:RID_WIDTH+128];
            hit_q <= bbox_resp_stream_rsc_dat[RID_WIDTH+194:RID_WIDTH+192];
            state <= SORT;
          end
        end
        SORT: begin
          ord_q <= sort_ord;
          cnt_q <= sort_cnt;
          ptr_q <= '0;
          state <= EMIT;
        end
        EMIT: begin
          if (cand_stream_rsc_rdy) begin
            if (beat.last) begin
              ptr_q <= '0;
              state <= IDLE;
            end else begin
              ptr_q <= ptr_q + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_cand_sorter.sv
// Directed and randomized checks of bbox_cand_sorter against a sign-magnitude float ordering model.
module tb_bbox_cand_sorter;
  localparam int RW = 16;

  logic            clk;
  logic            arst;
  logic [RW+194:0] bbox_resp_stream_rsc_dat;
  logic            bbox_resp_stream_rsc_vld;
  logic            bbox_resp_stream_rsc_rdy;
  logic [RW+36:0]  cand_stream_rsc_dat;
  logic            cand_stream_rsc_vld;
  logic            cand_stream_rsc_rdy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [RW+36:0] exp_q[$];
  bit soak_done = 0;

  bbox_cand_sorter #(.RID_WIDTH(RW)) dut (
    .clk                      (clk),
    .arst                     (arst),
    .bbox_resp_stream_rsc_dat (bbox_resp_stream_rsc_dat),
    .bbox_resp_stream_rsc_vld (bbox_resp_stream_rsc_vld),
    .bbox_resp_stream_rsc_rdy (bbox_resp_stream_rsc_rdy),
    .cand_stream_rsc_dat      (cand_stream_rsc_dat),
    .cand_stream_rsc_vld      (cand_stream_rsc_vld),
    .cand_stream_rsc_rdy      (cand_stream_rsc_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [RW+36:0] mkb(input logic last, input logic [1:0] cnt,
                                         input logic [1:0] idx, input logic [31:0] tmin,
                                         input logic [RW-1:0] rid);
    return {last, cnt, idx, tmin, rid};
  endfunction

  function automatic logic [RW+194:0] mk_in(input logic [RW-1:0] rid, input logic [2:0] hit,
                                            input logic [31:0] f0, input logic [31:0] f2,
                                            input logic [31:0] f4);
    return {hit, 32'($urandom), f4, 32'($urandom), f2, 32'($urandom), f0, rid};
  endfunction

  function automatic logic [31:0] rand_f();
    logic [31:0] f;
    case ($urandom_range(0, 7))
      0:       f = 32'h0000_0000;
      1:       f = 32'h8000_0000;
      2:       f = 32'h3F80_0000;
      3:       f = 32'hBF80_0000;
      default: f = {1'($urandom), 8'($urandom_range(0, 254)), 23'($urandom)};
    endcase
    return f;
  endfunction

  // Float ordering from IEEE sign-magnitude semantics: negatives below positives, -0 < +0.
  function automatic bit fless(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  function automatic void model_push(input logic [RW+194:0] d);
    logic [31:0] t[3];
    int ord[$];
    int tmp;
    logic [2:0] hit;
    logic [RW-1:0] rid;
    hit = d[RW+194:RW+192];
    rid = d[RW-1:0];
    for (int i = 0; i < 3; i++) begin
      t[i] = d[RW+64*i +: 32];
      if (hit[i]) ord.push_back(i);
    end
    for (int a = 1; a < ord.size(); a++) begin
      for (int b = a; b > 0; b--) begin
        if (!fless(t[ord[b]], t[ord[b-1]])) break;
        tmp = ord[b]; ord[b] = ord[b-1]; ord[b-1] = tmp;
      end
    end
    if (ord.size() == 0) begin
      exp_q.push_back(mkb(1'b1, 2'd0, 2'd3, 32'h0, rid));
    end else begin
      for (int k = 0; k < ord.size(); k++) begin
        exp_q.push_back(mkb(k == ord.size() - 1, 2'(ord.size()), 2'(ord[k]), t[ord[k]], rid));
      end
    end
  endfunction

  // Returns at posedge+1 of the accepting edge.
  task automatic send(input logic [RW+194:0] d);
    bit acc = 0;
    bbox_resp_stream_rsc_dat = d;
    bbox_resp_stream_rsc_vld = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bbox_resp_stream_rsc_rdy) begin
        acc = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bbox_resp_stream_rsc_vld = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic get_beat(output logic [RW+36:0] d);
    bit got = 0;
    d = '0;
    cand_stream_rsc_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cand_stream_rsc_vld) begin
        d = cand_stream_rsc_dat;
        got = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!got) chk("beat_timeout", 0, 1);
  endtask

  task automatic expect_beats(input string tag, input int n, input logic [2:0][1:0] idxs,
                              input logic [2:0][31:0] tmins, input logic [1:0] cnt,
                              input logic [RW-1:0] rid);
    logic [RW+36:0] d;
    for (int b = 0; b < n; b++) begin
      get_beat(d);
      chk($sformatf("%s_idx%0d", tag, b), d[RW+33:RW+32], idxs[b]);
      chk($sformatf("%s_tmin%0d", tag, b), d[RW+31:RW], tmins[b]);
      chk($sformatf("%s_cnt%0d", tag, b), d[RW+35:RW+34], cnt);
      chk($sformatf("%s_last%0d", tag, b), d[RW+36], b == n - 1);
      chk($sformatf("%s_rid%0d", tag, b), d[RW-1:0], rid);
    end
  endtask

  initial begin
    logic [RW+36:0] d;
    logic [RW+36:0] prev;
    logic [RW+36:0] got_b[2];
    logic [4:0] seq;
    int nb;
    bit ok;

    arst = 1'b0;
    bbox_resp_stream_rsc_vld = 1'b0;
    bbox_resp_stream_rsc_dat = '0;
    cand_stream_rsc_rdy = 1'b0;
    #1 arst = 1'b1;
    #1;
    chk("rst_in_rdy", bbox_resp_stream_rsc_rdy, 1);
    chk("rst_out_vld", cand_stream_rsc_vld, 0);
    chk("rst_out_dat", cand_stream_rsc_dat, 0);
    @(negedge clk) arst = 1'b0;
    @(posedge clk);
    #1;

    // Three hits, with first-beat latency.
    cand_stream_rsc_rdy = 1'b1;
    send(mk_in(16'd7, 3'b111, 32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000));
    chk("lat_sort_vld", cand_stream_rsc_vld, 0);
    chk("lat_sort_in_rdy", bbox_resp_stream_rsc_rdy, 0);
    @(posedge clk);
    #1;
    chk("lat_first_vld", cand_stream_rsc_vld, 1);
    expect_beats("three", 3, {2'd0, 2'd2, 2'd1},
                 {32'h4000_0000, 32'h3F80_0000, 32'h3F00_0000}, 2'd3, 16'd7);
    chk("three_idle_in_rdy", bbox_resp_stream_rsc_rdy, 1);
    chk("three_idle_vld", cand_stream_rsc_vld, 0);

    send(mk_in(16'd21, 3'b111, 32'hBF80_0000, 32'h3F80_0000, 32'h3F80_0000));
    expect_beats("sign_tie", 3, {2'd2, 2'd1, 2'd0},
                 {32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000}, 2'd3, 16'd21);

    send(mk_in(16'd22, 3'b011, 32'h0000_0000, 32'h8000_0000, 32'hBF80_0000));
    expect_beats("negzero", 2, {2'd3, 2'd0, 2'd1},
                 {32'h0, 32'h0000_0000, 32'h8000_0000}, 2'd2, 16'd22);

    send(mk_in(16'd9, 3'b000, rand_f(), rand_f(), rand_f()));
    expect_beats("nohit", 1, {2'd3, 2'd3, 2'd3}, {32'h0, 32'h0, 32'h0}, 2'd0, 16'd9);

    // Backpressure: rdy pattern 0,0,1,0,1 once the first beat is up.
    cand_stream_rsc_rdy = 1'b0;
    send(mk_in(16'd11, 3'b110, 32'hC0A0_0000, 32'h3F80_0000, 32'h3F00_0000));
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cand_stream_rsc_vld) begin
        ok = 1;
        break;
      end
    end
    chk("bp_first_vld", ok, 1);
    seq = 5'b10100;
    nb = 0;
    prev = cand_stream_rsc_dat;
    for (int c = 0; c < 5; c++) begin
      cand_stream_rsc_rdy = seq[c];
      chk($sformatf("bp_in_rdy%0d", c), bbox_resp_stream_rsc_rdy, 0);
      chk($sformatf("bp_vld%0d", c), cand_stream_rsc_vld, 1);
      if (c > 0 && !seq[c-1]) chk($sformatf("bp_hold%0d", c), cand_stream_rsc_dat, prev);
      if (seq[c] && nb < 2) begin
        got_b[nb] = cand_stream_rsc_dat;
        nb++;
      end
      prev = cand_stream_rsc_dat;
      @(negedge clk);
    end
    chk("bp_count", nb, 2);
    chk("bp_beat0", got_b[0], mkb(1'b0, 2'd2, 2'd2, 32'h3F00_0000, 16'd11));
    chk("bp_beat1", got_b[1], mkb(1'b1, 2'd2, 2'd1, 32'h3F80_0000, 16'd11));
    chk("bp_after_in_rdy", bbox_resp_stream_rsc_rdy, 1);
    chk("bp_after_vld", cand_stream_rsc_vld, 0);
    @(posedge clk);
    #1;

    // Reset during the second of three beats.
    cand_stream_rsc_rdy = 1'b1;
    send(mk_in(16'd3, 3'b111, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000));
    get_beat(d);
    chk("mid_first_idx", d[RW+33:RW+32], 0);
    chk("mid_second_vld", cand_stream_rsc_vld, 1);
    arst = 1'b1;
    #1;
    chk("mid_rst_vld", cand_stream_rsc_vld, 0);
    chk("mid_rst_in_rdy", bbox_resp_stream_rsc_rdy, 1);
    chk("mid_rst_dat", cand_stream_rsc_dat, 0);
    #2 arst = 1'b0;
    @(posedge clk);
    #1;
    send(mk_in(16'd5, 3'b001, 32'h3F80_0000, rand_f(), rand_f()));
    expect_beats("post_rst", 1, {2'd3, 2'd3, 2'd0}, {32'h0, 32'h0, 32'h3F80_0000}, 2'd1, 16'd5);
    chk("post_rst_idle_vld", cand_stream_rsc_vld, 0);

    // Randomized soak against the reference model.
    exp_q.delete();
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(mk_in(16'($urandom), 3'($urandom), rand_f(), rand_f(), rand_f()));
        end
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        soak_done = 1;
      end
      begin
        while (!soak_done) begin
          @(posedge clk);
          #1;
          cand_stream_rsc_rdy = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        bit stalled = 0;
        logic [RW+36:0] held = '0;
        while (!soak_done) begin
          @(negedge clk);
          if (stalled) begin
            chk("soak_stall_vld", cand_stream_rsc_vld, 1);
            chk("soak_stall_dat", cand_stream_rsc_dat, held);
          end
          if (bbox_resp_stream_rsc_vld && bbox_resp_stream_rsc_rdy)
            model_push(bbox_resp_stream_rsc_dat);
          if (cand_stream_rsc_vld && cand_stream_rsc_rdy) begin
            if (exp_q.size() == 0) chk("soak_extra_beat", cand_stream_rsc_dat, 0);
            else chk("soak_beat", cand_stream_rsc_dat, exp_q.pop_front());
          end
          stalled = cand_stream_rsc_vld && !cand_stream_rsc_rdy;
          held = cand_stream_rsc_dat;
        end
      end
    join
    chk("soak_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
